// File: rtl/cpu_step_controller.sv
// cpu_step_controller: clock-enable sequencer for the single-cycle 8-bit CPU.
// Produces a one-clock cpu_ce pulse at a programmable rate in RUN. Also produces
// one pulse per debounced press of the step key. A PC breakpoint halts RUN.
// The FSM state is exported on the state output so it can be observed directly.
module cpu_step_controller #(
    parameter int DIV_MAX         = 25000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PC_W            = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run_sw,
    input  logic            step_key_n,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    output logic            cpu_ce,
    output logic            tick_led,
    output logic            halted,
    output logic [1:0]      state
);

    localparam int DIV_W = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    logic             run_meta;
    logic             run_s;
    logic             key_meta;
    logic             key_s;
    logic             key_db;
    logic             key_db_d;
    logic [DB_W-1:0]  db_cnt;
    logic             step_req;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             ce_next;
    logic             armed;
    logic             bp_hit;
    logic             div_last;
    logic [1:0]       state_next;

    // Two-flop synchronizers; idle levels are switch off and key released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            run_meta <= run_sw;
            run_s    <= run_meta;
            key_meta <= step_key_n;
            key_s    <= key_meta;
        end
    end

    // Debounce: accept a new key level only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db   <= 1'b1;
            key_db_d <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_db_d <= key_db;
            if (key_s != key_db) begin
                if (db_cnt == DB_LAST) begin
                    key_db <= key_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // A press is the debounced 1->0 edge; a release produces nothing.
    assign step_req = key_db_d & ~key_db;

    assign div_last = (div == DIV_LAST);
    assign bp_hit   = bp_en && armed && (pc == bp_addr);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; run has priority over a step in IDLE, and a step has priority over run-off in BREAK.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (run_s) begin
                    state_next = ST_RUN;
                end else if (step_req) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!run_s) begin
                    state_next = ST_IDLE;
                end else if (div_last && bp_hit) begin
                    state_next = ST_BREAK;
                end
            end
            ST_STEP: begin
                state_next = run_s ? ST_RUN : ST_IDLE;
            end
            ST_BREAK: begin
                if (step_req) begin
                    state_next = ST_STEP;
                end else if (!run_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic. The divider only counts in RUN and is zero on every entry to RUN.
    // STEP never checks the breakpoint.
    always_comb begin
        ce_next  = 1'b0;
        div_next = '0;
        case (state)
            ST_RUN: begin
                if (run_s) begin
                    if (!div_last) begin
                        div_next = div + DIV_W'(1);
                    end else if (!bp_hit) begin
                        ce_next = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                ce_next = 1'b1;
            end
            default: begin
                ce_next  = 1'b0;
                div_next = '0;
            end
        endcase
    end

    // Registered outputs, divider and breakpoint arming.
    // The breakpoint is disarmed on BREAK entry and re-arms once pc leaves bp_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ce   <= 1'b0;
            tick_led <= 1'b0;
            halted   <= 1'b1;
            div      <= '0;
            armed    <= 1'b1;
        end else begin
            cpu_ce   <= ce_next;
            tick_led <= tick_led ^ ce_next;
            halted   <= (state_next == ST_IDLE) || (state_next == ST_BREAK);
            div      <= div_next;
            if (state == ST_RUN && state_next == ST_BREAK) begin
                armed <= 1'b0;
            end else if (pc != bp_addr) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed testbench for cpu_step_controller with DIV_MAX=4 and DEBOUNCE_CYCLES=3.
// The bench plays the CPU: it advances pc whenever it sees cpu_ce high.
module tb_cpu_step_controller;

    localparam int DIV_MAX = 4;
    localparam int DEB     = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_sw;
    logic       step_key_n;
    logic       bp_en;
    logic [7:0] bp_addr;
    logic [7:0] pc;
    logic       cpu_ce;
    logic       tick_led;
    logic       halted;
    logic [1:0] state;

    int         total = 0;
    int         bad   = 0;
    int         ce_cnt;
    logic       exp_tick;
    logic       prev_ce;
    logic       pc_inc;
    logic       saw_step;
    logic       saw_break;
    logic [7:0] last_ce_pc;
    logic [7:0] exp_q[$];

    cpu_step_controller #(
        .DIV_MAX        (DIV_MAX),
        .DEBOUNCE_CYCLES(DEB),
        .PC_W           (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_sw    (run_sw),
        .step_key_n(step_key_n),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_ce    (cpu_ce),
        .tick_led  (tick_led),
        .halted    (halted),
        .state     (state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 ns after the rising edge, act as the CPU, and check the per-cycle invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_ce === 1'b1) begin
            ce_cnt++;
            exp_tick   = ~exp_tick;
            last_ce_pc = pc;
            if (exp_q.size() > 0) begin
                chk("ce_pc_order", 32'(pc), 32'(exp_q.pop_front()));
            end
            if (pc_inc) pc = pc + 8'd1;
        end
        if (state === 2'd2) saw_step = 1'b1;
        if (state === 2'd3) saw_break = 1'b1;
        chk("tick_led_track", 32'(tick_led), 32'(exp_tick));
        chk("ce_not_back_to_back", 32'(prev_ce & cpu_ce), 32'd0);
        prev_ce = cpu_ce;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ce(input int budget, input string tag);
        int start;
        int n;
        start = ce_cnt;
        n = 0;
        while (ce_cnt == start && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(ce_cnt != start), 32'd1);
    endtask

    // Run from pc=0 with the breakpoint at 5: expect pulses at pc 0..4, then BREAK.
    task automatic run_to_break(input string tag);
        int n;
        ce_cnt = 0;
        n = 0;
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
        run_sw = 1'b1;
        while (state !== 2'd3 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_state"}, 32'(state), 32'd3);
        chk({tag, "_pulses"}, 32'(ce_cnt), 32'd5);
        chk({tag, "_pc"}, 32'(pc), 32'h05);
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b1;
        run_sw     = 1'b0;
        step_key_n = 1'b1;
        bp_en      = 1'b0;
        bp_addr    = 8'h05;
        pc         = 8'h00;
        pc_inc     = 1'b0;
        exp_tick   = 1'b0;
        prev_ce    = 1'b0;
        saw_step   = 1'b0;
        saw_break  = 1'b0;
        ce_cnt     = 0;
        last_ce_pc = 8'h00;

        // Reset.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_tick_led", 32'(tick_led), 32'd0);
        ticks(2);
        rst_n = 1'b1;

        // 1: continuous run at DIV_MAX, then stop.
        run_sw = 1'b1;
        ticks(2);
        chk("run_sync_delay", 32'(state), 32'd0);
        tick();
        chk("run_entry", 32'(state), 32'd1);
        chk("run_not_halted", 32'(halted), 32'd0);
        ce_cnt = 0;
        ticks(3);
        chk("no_early_ce", 32'(ce_cnt), 32'd0);
        tick();
        chk("first_ce_at_4", 32'(cpu_ce), 32'd1);
        chk("tick_led_first", 32'(tick_led), 32'd1);
        ticks(3);
        chk("gap_ce_low", 32'(cpu_ce), 32'd0);
        tick();
        chk("second_ce_at_8", 32'(cpu_ce), 32'd1);
        chk("tick_led_second", 32'(tick_led), 32'd0);
        run_sw = 1'b0;
        ticks(2);
        chk("run_drop_sync", 32'(state), 32'd1);
        tick();
        chk("run_drop_idle", 32'(state), 32'd0);
        chk("idle_halted", 32'(halted), 32'd1);
        ce_cnt = 0;
        ticks(20);
        chk("idle_no_ce", 32'(ce_cnt), 32'd0);

        // 2: glitchy press gives one step; release gives none; a second press gives another.
        ce_cnt = 0;
        saw_step = 1'b0;
        step_key_n = 1'b0;
        tick();
        step_key_n = 1'b1;
        tick();
        step_key_n = 1'b0;
        ticks(10);
        step_key_n = 1'b1;
        ticks(12);
        chk("glitch_press_one_ce", 32'(ce_cnt), 32'd1);
        chk("glitch_press_saw_step", 32'(saw_step), 32'd1);
        chk("glitch_press_back_idle", 32'(state), 32'd0);
        ce_cnt = 0;
        step_key_n = 1'b0;
        ticks(5);
        chk("press2_still_idle", 32'(state), 32'd0);
        tick();
        chk("press2_step_state", 32'(state), 32'd2);
        tick();
        chk("press2_ce", 32'(cpu_ce), 32'd1);
        chk("press2_idle", 32'(state), 32'd0);
        ticks(3);
        step_key_n = 1'b1;
        ticks(12);
        chk("press2_one_ce", 32'(ce_cnt), 32'd1);

        // 3: run into the breakpoint at 05.
        pc      = 8'h00;
        pc_inc  = 1'b1;
        bp_en   = 1'b1;
        bp_addr = 8'h05;
        run_to_break("bp1");
        ce_cnt = 0;
        ticks(50);
        chk("break_no_ce", 32'(ce_cnt), 32'd0);
        chk("break_holds", 32'(state), 32'd3);
        chk("break_pc_hold", 32'(pc), 32'h05);

        // 4a: step out of BREAK with run on; pulses resume.
        exp_q.push_back(8'h05);
        step_key_n = 1'b0;
        wait_ce(20, "bp_step_ce");
        chk("bp_step_pc_before", 32'(last_ce_pc), 32'h05);
        chk("bp_step_pc_after", 32'(pc), 32'h06);
        chk("bp_step_to_run", 32'(state), 32'd1);
        step_key_n = 1'b1;
        ce_cnt = 0;
        ticks(8);
        chk("run_resumes", 32'(ce_cnt), 32'd2);
        run_sw = 1'b0;
        ticks(6);
        chk("stop_after_resume", 32'(state), 32'd0);

        // 4b: step out of BREAK with run off; ends in IDLE.
        pc = 8'h00;
        run_to_break("bp2");
        exp_q.push_back(8'h05);
        run_sw = 1'b0;
        step_key_n = 1'b0;
        ce_cnt = 0;
        saw_step = 1'b0;
        ticks(3);
        chk("break_run_off_idle", 32'(state), 32'd0);
        ticks(7);
        step_key_n = 1'b1;
        ticks(15);
        chk("idle_step_one_ce", 32'(ce_cnt), 32'd1);
        chk("idle_step_saw_step", 32'(saw_step), 32'd1);
        chk("idle_step_end_idle", 32'(state), 32'd0);
        chk("idle_step_pc", 32'(pc), 32'h06);

        // 5: leave BREAK via IDLE and run again; runs past the disarmed breakpoint.
        pc = 8'h00;
        run_to_break("bp3");
        run_sw = 1'b0;
        ticks(4);
        chk("bp3_to_idle", 32'(state), 32'd0);
        exp_q.push_back(8'h05);
        run_sw = 1'b1;
        ce_cnt = 0;
        saw_break = 1'b0;
        wait_ce(10, "rerun_first_ce");
        chk("rerun_pc_at_ce", 32'(last_ce_pc), 32'h05);
        chk("rerun_state", 32'(state), 32'd1);
        ce_cnt = 0;
        ticks(40);
        chk("rerun_pulses", 32'(ce_cnt), 32'd10);
        chk("rerun_no_rebreak", 32'(saw_break), 32'd0);

        // 6: reset in RUN while div==3 drops the pending pulse.
        wait_ce(8, "pre_reset_ce");
        ticks(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd1);
        chk("midrst_tick_led", 32'(tick_led), 32'd0);
        exp_tick = 1'b0;
        prev_ce  = 1'b0;
        run_sw   = 1'b0;
        ce_cnt   = 0;
        ticks(2);
        rst_n = 1'b1;
        ticks(10);
        chk("midrst_no_ce", 32'(ce_cnt), 32'd0);
        chk("midrst_stays_idle", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_step_controller.md
Name: cpu_step_controller

Overview:
Sequencer for the single-cycle 8-bit CPU. It replaces the free-running clock divider with a clock-enable generator on CLOCK_50. It supports continuous run at a programmable rate, debounced single-step from a push-button, and halt on a PC breakpoint. Its cpu_ce output gates PC, register-file and store updates; the board drives run_sw, step_key_n and the breakpoint inputs.

Parameters:
DIV_MAX, 25000000, CLOCK_50 cycles between cpu_ce pulses in RUN (≥2).
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required before a button change is accepted (≥2).
PC_W, 8, PC / breakpoint address width.

Ports:
clk  in  1  system clock (CLOCK_50); all logic rising-edge.
rst_n  in  1  asynchronous, active-low reset.
run_sw  in  1  raw slide switch; 1 = run requested.
step_key_n  in  1  raw push-button, active-low (KEY style).
bp_en  in  1  breakpoint enable.
bp_addr  in  PC_W  breakpoint PC.
pc  in  PC_W  current CPU PC.
cpu_ce  out  1  one-clk-wide enable; the CPU commits exactly one instruction per pulse.
tick_led  out  1  toggles on every cpu_ce (LEDG indicator).
halted  out  1  1 in IDLE or BREAK.
state  out  2  IDLE=0, RUN=1, STEP=2, BREAK=3.

Behaviour:
- Reset (async, rst_n=0) sets the following:
  - cpu_ce=0, tick_led=0, state=IDLE, halted=1.
  - div counter=0, armed=1.
  - Synchronizer and debounce registers = idle levels (run=0, key=1).
- Input conditioning:
  - run_sw and step_key_n each pass through a 2-FF synchronizer.
  - step_key_n is additionally debounced: a counter increments while the synced value differs from the debounced value. When it reaches DEBOUNCE_CYCLES-1, the debounced value updates; any disagreement-free cycle clears the counter.
  - step_req is a 1-cycle pulse on the debounced 1→0 transition. Release generates nothing.
  - run_s is the synchronized run_sw (no debounce).
- armed register:
  - Cleared on BREAK entry.
  - Set in any cycle where pc != bp_addr.
- IDLE:
  - run_s=1 → RUN with div=0. This takes priority over a simultaneous step_req.
  - Otherwise step_req → STEP.
- RUN:
  - run_s=0 → IDLE; div cleared; no cpu_ce that cycle.
  - Otherwise div increments; at div==DIV_MAX-1, div wraps to 0 and one of two things happens:
    - If bp_en && armed && pc==bp_addr: go to BREAK, no cpu_ce.
    - Else: cpu_ce=1 next cycle.
  - step_req is ignored in RUN.
- STEP:
  - cpu_ce=1 for exactly one cycle (the cycle after STEP entry).
  - Then → RUN (div=0) if run_s=1, else → IDLE.
  - Breakpoints are not checked in STEP, so a step always executes the instruction at pc.
- BREAK:
  - step_req → STEP.
  - run_s=0 → IDLE.
  - Since armed=0, re-asserting run from IDLE runs past the breakpoint. armed re-sets once pc leaves bp_addr.
- cpu_ce timing and outputs:
  - cpu_ce is registered; it is never high for two consecutive cycles.
  - In RUN, cpu_ce fires every DIV_MAX cycles exactly, first pulse DIV_MAX cycles after RUN entry.
  - tick_led toggles on the same edge cpu_ce is asserted.
  - halted = (state==IDLE || state==BREAK), registered with state.
- Mid-operation reset: rst_n low in any state immediately forces the reset values; a pending cpu_ce is dropped.
- Button held: one step per press regardless of hold length; bounce shorter than DEBOUNCE_CYCLES yields no extra steps.

Test Plan:
(Bench uses DIV_MAX=4, DEBOUNCE_CYCLES=3.)
1. Reset, run_sw=1 held → state=1 after sync; cpu_ce pulses every 4 clks, first 4 clks after RUN entry. tick_led toggles each pulse. Drop run_sw → state=0, no further cpu_ce.
2. IDLE, step_key_n low for 10 clks with 1-clk glitches in the first 2 clks → exactly one cpu_ce, state goes 0→2→0. Release gives no pulse. A second press gives a second pulse.
3. RUN, bp_en=1, bp_addr=8'h05, bench increments pc on each cpu_ce from 0 → five pulses (pc 0..4). Then state=3, halted=1, pc stays 05, no cpu_ce for 50 clks.
4. From BREAK (run_sw=1), press step → one cpu_ce, pc→06, state→RUN, pulses resume. With run_sw=0 instead, state→IDLE after the step.
5. From BREAK, run_sw 1→0→1 → IDLE then RUN; the first tick issues cpu_ce at pc=05 (armed=0), and no re-break occurs.
6. Assert rst_n=0 mid-RUN on the cycle div==3 → no cpu_ce, all outputs at reset values, state=0, tick_led=0.
